// File: rtl/img2col_rd_ctrl.sv
// rtl/img2col_rd_ctrl.sv - im2col read sequencer streaming K x K patches from a row-major tensor RAM
//
// Walks one IMG_H x IMG_W feature map in im2col order (oy, ox, ky, kx) and
// streams every element through a 4-entry output FIFO.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin one frame (sampled only while idle)
//   busy, done        frame in progress / one-cycle completion pulse
//   ram_en, ram_we    RAM read strobe / write enable (always 0)
//   ram_addr          RAM read address
//   ram_dout          RAM read data, valid one cycle after ram_en
//   m_valid, m_ready  output stream handshake
//   m_data            output element
//   m_last            last element of the current patch
//   m_frame_last      last element of the frame
module img2col_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 10,
    parameter int IMG_H      = 8,
    parameter int IMG_W      = 8,
    parameter int K          = 3,
    parameter int STRIDE     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_SIZE-1:0]  ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_frame_last
);

    localparam int OH = (IMG_H - K) / STRIDE + 1;
    localparam int OW = (IMG_W - K) / STRIDE + 1;

    localparam logic [ADDR_SIZE-1:0] K_MAX     = ADDR_SIZE'(K - 1);
    localparam logic [ADDR_SIZE-1:0] OW_MAX    = ADDR_SIZE'(OW - 1);
    localparam logic [ADDR_SIZE-1:0] OH_MAX    = ADDR_SIZE'(OH - 1);
    localparam logic [ADDR_SIZE-1:0] ROW_STEP  = ADDR_SIZE'(IMG_W);
    localparam logic [ADDR_SIZE-1:0] COL_STEP  = ADDR_SIZE'(STRIDE);
    localparam logic [ADDR_SIZE-1:0] BAND_STEP = ADDR_SIZE'(STRIDE * IMG_W);
    localparam logic [ADDR_SIZE-1:0] ONE       = ADDR_SIZE'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state;
    logic [ADDR_SIZE-1:0] kx, ky, ox, oy;
    // band_base = start of window row band, patch_base = top-left of patch,
    // row_base = start of current kernel row, addr = element being issued.
    logic [ADDR_SIZE-1:0] band_base, patch_base, row_base, addr, last_addr;

    logic                  pend, pend_last, pend_flast;
    logic [DATA_WIDTH-1:0] fifo_data [4];
    logic [3:0]            fifo_last, fifo_flast;
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            count;

    logic issue, pop, is_last, is_flast;

    // Issue decision looks only at registered occupancy, so m_ready never
    // reaches ram_en combinationally.
    assign issue    = (state == S_RUN) && ((count + {2'b00, pend}) < 3'd4);
    assign is_last  = (kx == K_MAX) && (ky == K_MAX);
    assign is_flast = is_last && (ox == OW_MAX) && (oy == OH_MAX);
    assign pop      = m_valid & m_ready;

    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign ram_en       = issue;
    assign ram_we       = 1'b0;
    assign ram_addr     = issue ? addr : last_addr;
    assign m_valid      = (count != 3'd0);
    assign m_data       = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_last       = m_valid & fifo_last[rd_ptr];
    assign m_frame_last = m_valid & fifo_flast[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            kx         <= '0;
            ky         <= '0;
            ox         <= '0;
            oy         <= '0;
            band_base  <= '0;
            patch_base <= '0;
            row_base   <= '0;
            addr       <= '0;
            last_addr  <= '0;
            pend       <= 1'b0;
            pend_last  <= 1'b0;
            pend_flast <= 1'b0;
            fifo_last  <= '0;
            fifo_flast <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        kx         <= '0;
                        ky         <= '0;
                        ox         <= '0;
                        oy         <= '0;
                        band_base  <= '0;
                        patch_base <= '0;
                        row_base   <= '0;
                        addr       <= '0;
                    end
                end
                S_RUN:   if (issue && is_flast) state <= S_DRAIN;
                S_DRAIN: if (pop && m_frame_last) state <= S_DONE;
                default: state <= S_IDLE;
            endcase

            if (issue) begin
                last_addr <= addr;
                if (kx != K_MAX) begin
                    kx   <= kx + ONE;
                    addr <= addr + ONE;
                end else begin
                    kx <= '0;
                    if (ky != K_MAX) begin
                        ky       <= ky + ONE;
                        row_base <= row_base + ROW_STEP;
                        addr     <= row_base + ROW_STEP;
                    end else begin
                        ky <= '0;
                        if (ox != OW_MAX) begin
                            ox         <= ox + ONE;
                            patch_base <= patch_base + COL_STEP;
                            row_base   <= patch_base + COL_STEP;
                            addr       <= patch_base + COL_STEP;
                        end else begin
                            ox         <= '0;
                            oy         <= oy + ONE;
                            band_base  <= band_base + BAND_STEP;
                            patch_base <= band_base + BAND_STEP;
                            row_base   <= band_base + BAND_STEP;
                            addr       <= band_base + BAND_STEP;
                        end
                    end
                end
            end

            // Tags ride alongside the read so they land with its data.
            pend       <= issue;
            pend_last  <= is_last;
            pend_flast <= is_flast;

            if (pend) begin
                fifo_last[wr_ptr]  <= pend_last;
                fifo_flast[wr_ptr] <= pend_flast;
                wr_ptr             <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, pend} - {2'b00, pop};
        end
    end

    // Data storage needs no reset: an entry is only visible once counted.
    always_ff @(posedge clk) begin
        if (pend) fifo_data[wr_ptr] <= ram_dout;
    end

endmodule

// File: tb/tb_img2col_rd_ctrl.sv
// tb/tb_img2col_rd_ctrl.sv - directed self-checking bench for img2col_rd_ctrl
module tb_img2col_rd_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v   [3];
    logic       start_v [3];
    logic       ready_v [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       en_v    [3];
    logic       we_v    [3];
    logic       valid_v [3];
    logic       last_v  [3];
    logic       flast_v [3];
    logic [9:0] addr_v  [3];
    logic [7:0] dout_v  [3];
    logic [7:0] data_v  [3];

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int hh [3] = '{4, 5, 3};
    int ss [3] = '{1, 2, 1};

    img2col_rd_ctrl #(.DATA_WIDTH(8), .ADDR_SIZE(10), .IMG_H(4), .IMG_W(4), .K(3), .STRIDE(1)) u_a (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .ram_en(en_v[0]), .ram_we(we_v[0]), .ram_addr(addr_v[0]), .ram_dout(dout_v[0]),
        .m_valid(valid_v[0]), .m_ready(ready_v[0]), .m_data(data_v[0]),
        .m_last(last_v[0]), .m_frame_last(flast_v[0]));

    img2col_rd_ctrl #(.DATA_WIDTH(8), .ADDR_SIZE(10), .IMG_H(5), .IMG_W(5), .K(3), .STRIDE(2)) u_b (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .ram_en(en_v[1]), .ram_we(we_v[1]), .ram_addr(addr_v[1]), .ram_dout(dout_v[1]),
        .m_valid(valid_v[1]), .m_ready(ready_v[1]), .m_data(data_v[1]),
        .m_last(last_v[1]), .m_frame_last(flast_v[1]));

    img2col_rd_ctrl #(.DATA_WIDTH(8), .ADDR_SIZE(10), .IMG_H(3), .IMG_W(3), .K(3), .STRIDE(1)) u_c (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .ram_en(en_v[2]), .ram_we(we_v[2]), .ram_addr(addr_v[2]), .ram_dout(dout_v[2]),
        .m_valid(valid_v[2]), .m_ready(ready_v[2]), .m_data(data_v[2]),
        .m_last(last_v[2]), .m_frame_last(flast_v[2]));

    // RAM contents mem[i] = i, one-cycle read latency.
    for (genvar g = 0; g < 3; g++) begin : g_ram
        always @(posedge clk) if (en_v[g]) dout_v[g] <= addr_v[g][7:0];
    end

    task automatic build_exp(input int s);
        int oh, ow;
        oh = (hh[s] - 3) / ss[s] + 1;
        ow = oh;
        exp_q.delete();
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        exp_q.push_back((oy * ss[s] + ky) * hh[s] + ox * ss[s] + kx);
    endtask

    // One frame on instance s; pct = percentage of cycles with m_ready high.
    task automatic run_frame(input int s, input int pct, input bit timing, input bit dup_start);
        int n, cyc, iss, hs, writes, occ, dones, first_valid, fl_cyc;
        bit en_d1, en_d2, stall;
        logic [7:0] pd;
        logic pl, pf;
        build_exp(s);
        n = exp_q.size();
        cyc = 0; iss = 0; hs = 0; writes = 0; dones = 0;
        first_valid = -1; fl_cyc = -1;
        en_d1 = 1'b0; en_d2 = 1'b0; stall = 1'b0;
        pd = '0; pl = 1'b0; pf = 1'b0;
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        cyc = 1;
        while (1) begin
            ready_v[s] = ($urandom_range(99) < pct);
            start_v[s] = dup_start && (cyc == 5 || cyc == 20);
            writes += int'(en_d2);
            occ = writes - hs;
            checks++;
            if (valid_v[s] !== (occ > 0) || occ > 4) begin
                errors++;
                $display("FAIL occupancy s%0d cyc%0d: m_valid=%b occ=%0d, want m_valid=%b occ<=4", s, cyc, valid_v[s], occ, occ > 0);
            end
            checks++;
            if (we_v[s] !== 1'b0) begin
                errors++;
                $display("FAIL ram_we s%0d cyc%0d: got %b want 0", s, cyc, we_v[s]);
            end
            if (timing && cyc == 1) begin
                checks++;
                if ({busy_v[s], en_v[s], addr_v[s]} !== {1'b1, 1'b1, 10'd0}) begin
                    errors++;
                    $display("FAIL first_cycle s%0d: busy=%b en=%b addr=%0d want 1 1 0", s, busy_v[s], en_v[s], addr_v[s]);
                end
            end
            if (valid_v[s] === 1'b1 && first_valid < 0) first_valid = cyc;
            if (en_v[s] === 1'b1) begin
                checks++;
                if (iss >= n || addr_v[s] !== 10'(exp_q[iss])) begin
                    errors++;
                    $display("FAIL read_addr s%0d idx%0d: got %0d want %0d", s, iss, addr_v[s], (iss < n) ? exp_q[iss] : -1);
                end
                iss++;
            end
            if (stall) begin
                checks++;
                if ({data_v[s], last_v[s], flast_v[s]} !== {pd, pl, pf}) begin
                    errors++;
                    $display("FAIL stall_hold s%0d cyc%0d: got %0d/%b/%b want %0d/%b/%b", s, cyc, data_v[s], last_v[s], flast_v[s], pd, pl, pf);
                end
            end
            if (valid_v[s] === 1'b1 && ready_v[s]) begin
                checks++;
                if (hs >= n || data_v[s] !== 8'(exp_q[hs]) || last_v[s] !== ((hs % 9) == 8) || flast_v[s] !== (hs == n - 1)) begin
                    errors++;
                    $display("FAIL element s%0d idx%0d: got %0d last=%b flast=%b want %0d last=%b flast=%b", s, hs,
                             data_v[s], last_v[s], flast_v[s], (hs < n) ? exp_q[hs] : -1, (hs % 9) == 8, hs == n - 1);
                end
                if (flast_v[s] === 1'b1) fl_cyc = cyc;
                hs++;
            end
            stall = (valid_v[s] === 1'b1) && !ready_v[s];
            pd = data_v[s]; pl = last_v[s]; pf = flast_v[s];
            if (done_v[s] === 1'b1) dones++;
            if (fl_cyc >= 0 && cyc == fl_cyc + 1) begin
                checks++;
                if ({done_v[s], busy_v[s]} !== 2'b11) begin
                    errors++;
                    $display("FAIL done_pulse s%0d: done=%b busy=%b want 1 1", s, done_v[s], busy_v[s]);
                end
            end
            if (fl_cyc >= 0 && cyc == fl_cyc + 2) begin
                checks++;
                if ({done_v[s], busy_v[s]} !== 2'b00) begin
                    errors++;
                    $display("FAIL after_done s%0d: done=%b busy=%b want 0 0", s, done_v[s], busy_v[s]);
                end
                break;
            end
            if (cyc >= 3000) begin
                checks++;
                errors++;
                $display("FAIL frame_timeout s%0d: got %0d elements want %0d", s, hs, n);
                break;
            end
            en_d2 = en_d1;
            en_d1 = (en_v[s] === 1'b1);
            @(negedge clk);
            cyc++;
        end
        ready_v[s] = 1'b0;
        start_v[s] = 1'b0;
        checks++;
        if (hs != n || iss != n || dones != 1) begin
            errors++;
            $display("FAIL frame_totals s%0d: elems=%0d reads=%0d dones=%0d want %0d %0d 1", s, hs, iss, dones, n, n);
        end
        if (timing) begin
            checks++;
            if (first_valid != 3 || fl_cyc != n + 2) begin
                errors++;
                $display("FAIL latency s%0d: first_valid=%0d last_cyc=%0d want 3 %0d", s, first_valid, fl_cyc, n + 2);
            end
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            rst_v[s] = 1'b1; start_v[s] = 1'b0; ready_v[s] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({busy_v[s], done_v[s], en_v[s], we_v[s], valid_v[s], last_v[s], flast_v[s], addr_v[s], data_v[s]} !== 25'd0) begin
                errors++;
                $display("FAIL reset_values s%0d: busy=%b done=%b en=%b we=%b valid=%b last=%b flast=%b addr=%0d data=%0d want all 0",
                         s, busy_v[s], done_v[s], en_v[s], we_v[s], valid_v[s], last_v[s], flast_v[s], addr_v[s], data_v[s]);
            end
            rst_v[s] = 1'b0;
        end
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({busy_v[s], en_v[s], valid_v[s]} !== 3'b000) begin
                errors++;
                $display("FAIL idle_after_reset s%0d: busy=%b en=%b valid=%b want 0 0 0", s, busy_v[s], en_v[s], valid_v[s]);
            end
        end
    endtask

    task automatic test_basic_stream();
        run_frame(0, 100, 1'b1, 1'b0);
    endtask

    task automatic test_stride2();
        run_frame(1, 100, 1'b1, 1'b0);
    endtask

    task automatic test_full_kernel();
        run_frame(2, 100, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame(0, 30, 1'b0, 1'b0);
        run_frame(0, 30, 1'b0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_frame(0, 100, 1'b1, 1'b1);
        run_frame(0, 100, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int hs, t;
        build_exp(0);
        hs = 0; t = 0;
        start_v[0] = 1'b1; ready_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        while (hs < 12 && t < 200) begin
            if (valid_v[0] === 1'b1) hs++;
            @(negedge clk);
            t++;
        end
        ready_v[0] = 1'b0;
        checks++;
        if (hs != 12) begin
            errors++;
            $display("FAIL midframe_reach s%0d: got %0d handshakes want 12", 0, hs);
        end
        repeat (8) @(negedge clk);
        checks++;
        if ({valid_v[0], last_v[0], data_v[0]} !== {1'b1, 1'b0, 8'(exp_q[12])}) begin
            errors++;
            $display("FAIL midframe_head: valid=%b last=%b data=%0d want 1 0 %0d", valid_v[0], last_v[0], data_v[0], exp_q[12]);
        end
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        checks++;
        if ({busy_v[0], done_v[0], en_v[0], we_v[0], valid_v[0], last_v[0], flast_v[0], addr_v[0], data_v[0]} !== 25'd0) begin
            errors++;
            $display("FAIL midframe_reset: busy=%b done=%b en=%b valid=%b last=%b flast=%b addr=%0d data=%0d want all 0",
                     busy_v[0], done_v[0], en_v[0], valid_v[0], last_v[0], flast_v[0], addr_v[0], data_v[0]);
        end
        ready_v[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({busy_v[0], valid_v[0]} !== 2'b00) begin
                errors++;
                $display("FAIL stale_output cyc%0d: busy=%b valid=%b want 0 0", i, busy_v[0], valid_v[0]);
            end
        end
        ready_v[0] = 1'b0;
        run_frame(0, 100, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_stride2();
        test_full_kernel();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
